// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// EX/MEM pipeline register of the 5-stage MIPS pipeline. It drives the data
// memory strobes and the word address directly from registers. It carries
// the writeback controls and the ALU result forward to MEM/WB.
//
// Each access is checked for misalignment, an out-of-range address, and
// conflicting read/write controls. A rejected access has its strobes and its
// writeback suppressed, and it raises mem_addr_err.
//
// Parameters
//   ADDR_W : data-memory word-address width (9)
//   DATA_W : datapath width (32)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          hold the stage / replace the stage with a bubble
//   ex_*                  fields from the EX stage
//   mem_valid             stage holds a real instruction
//   MemAddr/MemRead/MemWrite/Write_Data   data-memory interface
//   mem_alu_result, mem_rd, mem_reg_write, mem_mem_to_reg   to MEM/WB
//   mem_addr_err          access in this stage was rejected
//
// Optional build macro MEM_ACCESS_CNT_EN adds two counters:
//   ld_cnt : number of accepted loads
//   st_cnt : number of accepted stores
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] Write_Data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [4:0]        mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic              mem_addr_err
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]       ld_cnt,
  output logic [31:0]       st_cnt
`endif
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_read;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_alu;
  logic [4:0]        r_rd;
  logic              r_regWrite;
  logic              r_memToReg;
  logic              r_err;

  logic w_access;
  logic w_misaligned;
  logic w_outOfRange;
  logic w_conflict;
  logic w_reject;
  logic w_load;
  logic w_ldAccept;
  logic w_stAccept;

  // The check only applies to a real memory instruction. The upper address
  // bits must be zero so that the byte address fits inside the memory.
  assign w_access     = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_misaligned = |ex_alu_result[1:0];
  assign w_outOfRange = |ex_alu_result[DATA_W-1:ADDR_W+2];
  assign w_conflict   = ex_mem_read & ex_mem_write;
  assign w_reject     = w_access & (w_misaligned | w_outOfRange | w_conflict);
  assign w_load       = ~flush & ~stall;
  assign w_ldAccept   = w_load & ex_valid & ex_mem_read & ~w_reject;
  assign w_stAccept   = w_load & ex_valid & ex_mem_write & ~w_reject;

  // Priority: reset > flush > stall > load. A stall holds everything,
  // including MemWrite, because rewriting the same word is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_alu      <= '0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
      r_memToReg <= 1'b0;
      r_err      <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_alu      <= '0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
      r_memToReg <= 1'b0;
      r_err      <= 1'b0;
    end else if (!stall) begin
      // Data fields are captured even for bubbles and for rejected accesses.
      // Only the strobes and writeback are gated.
      r_valid    <= ex_valid;
      r_addr     <= ex_alu_result[ADDR_W+1:2];
      r_wdata    <= ex_store_data;
      r_alu      <= ex_alu_result;
      r_rd       <= ex_rd;
      r_memToReg <= ex_mem_to_reg;
      r_read     <= ex_valid & ex_mem_read & ~w_reject;
      r_write    <= ex_valid & ex_mem_write & ~w_reject;
      r_regWrite <= ex_valid & ex_reg_write & ~w_reject;
      r_err      <= w_reject;
    end
  end

  assign mem_valid      = r_valid;
  assign MemAddr        = r_addr;
  assign MemRead        = r_read;
  assign MemWrite       = r_write;
  assign Write_Data     = r_wdata;
  assign mem_alu_result = r_alu;
  assign mem_rd         = r_rd;
  assign mem_reg_write  = r_regWrite;
  assign mem_mem_to_reg = r_memToReg;
  assign mem_addr_err   = r_err;

`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] r_ldCnt;
  logic [31:0] r_stCnt;

  // The counters survive a flush. Only a loaded, accepted access counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ldCnt <= '0;
      r_stCnt <= '0;
    end else begin
      if (w_ldAccept) r_ldCnt <= r_ldCnt + 32'd1;
      if (w_stAccept) r_stCnt <= r_stCnt + 32'd1;
    end
  end

  assign ld_cnt = r_ldCnt;
  assign st_cnt = r_stCnt;
`else
  logic w_unusedAccept;
  assign w_unusedAccept = w_ldAccept | w_stAccept;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
// Scoreboard bench for ex_mem_reg. The driver applies one EX-stage input set
// before each rising edge. It computes the expected stage contents from the
// access rules using plain arithmetic, and pushes them into a queue. A
// separate monitor pops one entry after each rising edge and compares it
// with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef struct {
    bit          valid;
    int unsigned addr;
    bit          rdS;
    bit          wrS;
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    bit          regW;
    bit          m2r;
    bit          err;
    int unsigned ldc;
    int unsigned stc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush, ex_valid;
  logic [DATA_W-1:0] ex_alu_result, ex_store_data;
  logic [4:0]        ex_rd;
  logic              ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic              mem_valid;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRead, MemWrite;
  logic [DATA_W-1:0] Write_Data, mem_alu_result;
  logic [4:0]        mem_rd;
  logic              mem_reg_write, mem_mem_to_reg, mem_addr_err;
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0]       ld_cnt, st_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t mdl;
  exp_t zeroExp;

  ex_mem_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_valid(mem_valid), .MemAddr(MemAddr), .MemRead(MemRead),
    .MemWrite(MemWrite), .Write_Data(Write_Data),
    .mem_alu_result(mem_alu_result), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_addr_err(mem_addr_err)
`ifdef MEM_ACCESS_CNT_EN
    , .ld_cnt(ld_cnt), .st_cnt(st_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("mem_valid", {31'd0, mem_valid}, {31'd0, e.valid});
    cmp("MemAddr", {23'd0, MemAddr}, e.addr);
    cmp("MemRead", {31'd0, MemRead}, {31'd0, e.rdS});
    cmp("MemWrite", {31'd0, MemWrite}, {31'd0, e.wrS});
    cmp("Write_Data", Write_Data, e.wdata);
    cmp("mem_alu_result", mem_alu_result, e.alu);
    cmp("mem_rd", {27'd0, mem_rd}, {27'd0, e.rd});
    cmp("mem_reg_write", {31'd0, mem_reg_write}, {31'd0, e.regW});
    cmp("mem_mem_to_reg", {31'd0, mem_mem_to_reg}, {31'd0, e.m2r});
    cmp("mem_addr_err", {31'd0, mem_addr_err}, {31'd0, e.err});
`ifdef MEM_ACCESS_CNT_EN
    cmp("ld_cnt", ld_cnt, e.ldc);
    cmp("st_cnt", st_cnt, e.stc);
`endif
  endtask

  // Drive one input set before the next rising edge and predict the result.
  task automatic applyStimulus(input bit v, input logic [31:0] alu, input logic [31:0] sd,
                               input logic [4:0] rd, input bit mr, input bit mw,
                               input bit rw, input bit m2r, input bit st, input bit fl);
    longint unsigned a;
    bit bad;
    @(negedge clk);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_mem_to_reg = m2r;
    stall = st; flush = fl;
    a = longint'(alu);
    if (fl) begin
      mdl.valid = 0; mdl.addr = 0; mdl.rdS = 0; mdl.wrS = 0; mdl.wdata = 0;
      mdl.alu = 0; mdl.rd = 0; mdl.regW = 0; mdl.m2r = 0; mdl.err = 0;
    end else if (!st) begin
      bad = v && (mr || mw) &&
            ((a % 4) != 0 || a >= (64'd1 << (ADDR_W + 2)) || (mr && mw));
      mdl.valid = v;
      mdl.addr  = int'((a / 4) % (64'd1 << ADDR_W));
      mdl.wdata = sd;
      mdl.alu   = alu;
      mdl.rd    = rd;
      mdl.m2r   = m2r;
      mdl.err   = bad;
      mdl.rdS   = v && !bad && mr;
      mdl.wrS   = v && !bad && mw;
      mdl.regW  = v && !bad && rw;
      if (mdl.rdS) mdl.ldc++;
      if (mdl.wrS) mdl.stc++;
    end
    expQ.push_back(mdl);
  endtask

  // Monitor: after each rising edge, compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] alu;
    bit mr, mw;
    zeroExp = '{default: 0};
    mdl = zeroExp;
    rst_n = 1'b0; stall = 0; flush = 0; ex_valid = 0; ex_alu_result = 0;
    ex_store_data = 0; ex_rd = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_reg_write = 0; ex_mem_to_reg = 0;
    #1;
    checkOutput(zeroExp);
    #7 rst_n = 1'b1;

    // Store to byte address 0x10.
    applyStimulus(1, 32'h10, 32'hFE923F55, 5'd0, 0, 1, 0, 0, 0, 0);
    // Load at 0x20, then hold it for two stall cycles.
    applyStimulus(1, 32'h20, 32'h1234, 5'd7, 1, 0, 1, 1, 0, 0);
    applyStimulus(0, 32'h44, 32'h0, 5'd1, 0, 1, 0, 0, 1, 0);
    applyStimulus(1, 32'h48, 32'h0, 5'd2, 1, 0, 1, 0, 1, 0);
    // Misaligned load, then the top legal word, then the first illegal word.
    applyStimulus(1, 32'h22, 32'h0, 5'd3, 1, 0, 1, 1, 0, 0);
    applyStimulus(1, 32'h7FC, 32'h0, 5'd4, 1, 0, 1, 1, 0, 0);
    applyStimulus(1, 32'h800, 32'h0, 5'd5, 1, 0, 1, 1, 0, 0);
    // Conflicting controls.
    applyStimulus(1, 32'h0, 32'hAA, 5'd6, 1, 1, 1, 0, 0, 0);
    // Bubble with data present.
    applyStimulus(0, 32'h30, 32'h55, 5'd9, 1, 1, 1, 1, 0, 0);
    // Hold a store, then flush together with stall.
    applyStimulus(1, 32'h40, 32'hCAFE, 5'd0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 32'h44, 32'hBEEF, 5'd0, 0, 1, 0, 0, 1, 0);
    applyStimulus(1, 32'h48, 32'hF00D, 5'd0, 0, 1, 0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 5))
        0: alu = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
        1: alu = 32'h7FC;
        2: alu = 32'h800;
        3: alu = {20'd0, 12'($urandom_range(0, 4095))};
        4: alu = $urandom;
        default: alu = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      endcase
      mr = $urandom_range(0, 2) == 0;
      mw = $urandom_range(0, 2) == 0;
      applyStimulus($urandom_range(0, 4) != 0, alu, $urandom, 5'($urandom),
                    mr, mw, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset in the middle of a cycle while a store is active.
    applyStimulus(1, 32'h10, 32'h13579BDF, 5'd0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(zeroExp);
    mdl = zeroExp;
    stall = 1'b1;
    #1 rst_n = 1'b1;
    // Released during a stall: the stage stays a bubble until the first load.
    applyStimulus(1, 32'h24, 32'h1, 5'd1, 1, 0, 1, 0, 1, 0);
    applyStimulus(1, 32'h24, 32'h1, 5'd1, 1, 0, 1, 0, 1, 0);
    applyStimulus(1, 32'h24, 32'h1, 5'd1, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #3;
    cmp("queueDrain", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
